// File: rtl/pkt_pkg.sv
// Shared definitions for the packet TX framer and the receive-side sync detector.
package pkt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SYNC,
    ST_PAYLOAD,
    ST_TAIL
  } tx_state_e;

  localparam int unsigned PKT_PREAMBLE_BITS = 8;
  localparam int unsigned PKT_SYNC_BITS     = 16;
  localparam logic [15:0] PKT_SYNC_WORD     = 16'hD391;
  // 8 bytes matches the 64-bit receive packet register
  localparam int unsigned PKT_PAYLOAD_BYTES = 8;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pkt_payload_buf.sv
// Payload register file: byte-wide write port, single-bit read port.
module pkt_payload_buf #(
  parameter int unsigned PAYLOAD_BYTES = 8,
  parameter int unsigned IDX_W         = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [7:0]       data,
  input  logic [IDX_W-1:0] rd_byte,
  input  logic [2:0]       rd_bit,
  output logic             rd_data
);

  // Contents are don't-care after reset, so no reset on the array.
  logic [7:0] mem [PAYLOAD_BYTES];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= data;
  end

  assign rd_data = mem[rd_byte][rd_bit];

endmodule

// File: rtl/pkt_framer_tx.sv
// Transmit framer: buffers payload bytes, then serializes preamble, sync word
// and payload onto tx_out, one bit per sh_en strobe.
module pkt_framer_tx
  import pkt_pkg::*;
#(
  parameter int unsigned          PAYLOAD_BYTES = PKT_PAYLOAD_BYTES,
  parameter int unsigned          PREAMBLE_BITS = PKT_PREAMBLE_BITS,
  parameter int unsigned          SYNC_BITS     = PKT_SYNC_BITS,
  parameter logic [SYNC_BITS-1:0] SYNC_WORD     = SYNC_BITS'(PKT_SYNC_WORD)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sh_en,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  input  logic       start,
  input  logic       abort,
  output logic       tx_out,
  output logic       busy,
  output logic       tx_done,
  output logic       err
);

  localparam int unsigned BC_W  = $clog2(max3(PREAMBLE_BITS, SYNC_BITS, 8 * PAYLOAD_BYTES) + 1);
  localparam int unsigned WR_W  = $clog2(PAYLOAD_BYTES + 1);
  localparam int unsigned IDX_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;

  localparam logic [BC_W-1:0] PRE_LAST  = BC_W'(PREAMBLE_BITS - 1);
  localparam logic [BC_W-1:0] SYNC_LAST = BC_W'(SYNC_BITS - 1);
  localparam logic [BC_W-1:0] PAY_LAST  = BC_W'(8 * PAYLOAD_BYTES - 1);
  localparam logic [WR_W-1:0] WR_FULL   = WR_W'(PAYLOAD_BYTES);

  tx_state_e            state, state_d;
  logic [WR_W-1:0]      wr_idx, wr_idx_d;
  logic [BC_W-1:0]      bit_cnt, bit_cnt_d;
  logic                 tx_out_d, tx_done_d, err_d;
  logic                 buf_we, start_ok, pay_bit;
  logic [SYNC_BITS-1:0] sync_sh;

  assign byte_ready = (state == ST_IDLE) && (wr_idx < WR_FULL);
  assign sync_sh    = SYNC_WORD << bit_cnt;

  pkt_payload_buf #(
    .PAYLOAD_BYTES(PAYLOAD_BYTES),
    .IDX_W        (IDX_W)
  ) u_buf (
    .clk    (clk),
    .we     (buf_we),
    .idx    (IDX_W'(wr_idx)),
    .data   (byte_data),
    .rd_byte(IDX_W'(bit_cnt >> 3)),
    .rd_bit (~bit_cnt[2:0]),
    .rd_data(pay_bit)
  );

  always_comb begin
    state_d   = state;
    wr_idx_d  = wr_idx;
    bit_cnt_d = bit_cnt;
    tx_out_d  = tx_out;
    tx_done_d = 1'b0;
    err_d     = 1'b0;
    buf_we    = 1'b0;
    // Judged on the pre-write wr_idx: a write that fills the buffer cannot
    // enable a start in the same cycle.
    start_ok  = (state == ST_IDLE) && (wr_idx == WR_FULL);

    if (abort) begin
      state_d   = ST_IDLE;
      wr_idx_d  = '0;
      bit_cnt_d = '0;
      tx_out_d  = 1'b0;
    end else begin
      if (byte_valid) begin
        if (byte_ready) begin
          buf_we   = 1'b1;
          wr_idx_d = wr_idx + 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end

      if (start) begin
        if (start_ok) begin
          state_d   = ST_PREAMBLE;
          bit_cnt_d = '0;
        end else begin
          err_d = 1'b1;
        end
      end

      if (sh_en) begin
        case (state)
          ST_PREAMBLE: begin
            tx_out_d = ~bit_cnt[0];
            if (bit_cnt == PRE_LAST) begin
              state_d   = ST_SYNC;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt + 1'b1;
            end
          end
          ST_SYNC: begin
            tx_out_d = sync_sh[SYNC_BITS-1];
            if (bit_cnt == SYNC_LAST) begin
              state_d   = ST_PAYLOAD;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt + 1'b1;
            end
          end
          ST_PAYLOAD: begin
            tx_out_d = pay_bit;
            if (bit_cnt == PAY_LAST) begin
              state_d   = ST_TAIL;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt + 1'b1;
            end
          end
          ST_TAIL: begin
            tx_out_d  = 1'b0;
            tx_done_d = 1'b1;
            wr_idx_d  = '0;
            state_d   = ST_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      wr_idx  <= '0;
      bit_cnt <= '0;
      tx_out  <= 1'b0;
      busy    <= 1'b0;
      tx_done <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_d;
      wr_idx  <= wr_idx_d;
      bit_cnt <= bit_cnt_d;
      tx_out  <= tx_out_d;
      busy    <= (state_d != ST_IDLE);
      tx_done <= tx_done_d;
      err     <= err_d;
    end
  end

endmodule
